// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - opcodes, M-extension op codes and muldiv FSM states for the EX stage
package core_pkg;

  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] OPCODE_I      = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_PIM    = 7'b0001011;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_e;

endpackage

// File: rtl/core_muldiv_unit.sv
// rtl/core_muldiv_unit.sv - M-extension multiply/divide engine with busy/done handshake
// Product and first divide step are formed on the start edge; divide then retires DIV_BITS_PER_CYCLE bits per clock.
module core_muldiv_unit
  import core_pkg::*;
#(
  parameter int XLEN               = 32,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  md_op_e          op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int K  = XLEN / DIV_BITS_PER_CYCLE;
  localparam int CW = $clog2(K + 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  md_op_e          op_q, op_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dmag_q, dmag_d, result_q, result_d;
  logic            neg_q_q, neg_q_d, neg_r_q, neg_r_d;

  logic              div_signed, a_neg, b_neg, mul_a_s, mul_b_s;
  logic              is_mul, is_quot_in, div_by_zero, overflow;
  logic [XLEN-1:0]   a_mag, b_mag, special_res, fix_q, fix_r;
  logic [2*XLEN+1:0] ext_a, ext_b, product;
  logic [XLEN-1:0]   in_r, in_q, step_d, step_q;
  logic [XLEN:0]     step_r;

  assign is_mul      = op_i inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU};
  assign is_quot_in  = op_i inside {MD_DIV, MD_DIVU};
  assign div_signed  = op_i inside {MD_DIV, MD_REM};
  assign a_neg       = div_signed & a_i[XLEN-1];
  assign b_neg       = div_signed & b_i[XLEN-1];
  assign a_mag       = a_neg ? -a_i : a_i;
  assign b_mag       = b_neg ? -b_i : b_i;
  assign div_by_zero = (b_i == '0);
  assign overflow    = div_signed && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
  assign special_res = div_by_zero ? (is_quot_in ? '1 : a_i) : (is_quot_in ? a_i : '0);

  // Sign-extend into a 2*XLEN+2 field so one unsigned multiply covers all four variants.
  assign mul_a_s = (op_i == MD_MULH || op_i == MD_MULHSU) && a_i[XLEN-1];
  assign mul_b_s = (op_i == MD_MULH) && b_i[XLEN-1];
  assign ext_a   = {{(XLEN+2){mul_a_s}}, a_i};
  assign ext_b   = {{(XLEN+2){mul_b_s}}, b_i};
  assign product = ext_a * ext_b;

  always_comb begin
    in_r   = (state_q == DIV) ? rem_q  : '0;
    in_q   = (state_q == DIV) ? quo_q  : a_mag;
    step_d = (state_q == DIV) ? dmag_q : b_mag;
    step_r = {1'b0, in_r};
    step_q = in_q;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      step_r = {step_r[XLEN-1:0], step_q[XLEN-1]};
      step_q = {step_q[XLEN-2:0], 1'b0};
      if (step_r >= {1'b0, step_d}) begin
        step_r    = step_r - {1'b0, step_d};
        step_q[0] = 1'b1;
      end
    end
  end

  assign fix_q = neg_q_q ? -step_q : step_q;
  assign fix_r = neg_r_q ? -step_r[XLEN-1:0] : step_r[XLEN-1:0];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dmag_d   = dmag_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          busy_o = 1'b1;
          op_d   = op_i;
          if (is_mul) begin
            result_d = (op_i == MD_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
            state_d  = DONE;
          end else if (div_by_zero || overflow) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            rem_d   = step_r[XLEN-1:0];
            quo_d   = step_q;
            dmag_d  = b_mag;
            neg_q_d = a_neg ^ b_neg;
            neg_r_d = a_neg;
            count_d = CW'(K - 1);
            state_d = DIV;
          end
        end
      end
      MUL: begin
        busy_o  = 1'b1;
        state_d = DONE;
      end
      DIV: begin
        busy_o  = 1'b1;
        rem_d   = step_r[XLEN-1:0];
        quo_d   = step_q;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          result_d = (op_q inside {MD_DIV, MD_DIVU}) ? fix_q : fix_r;
          state_d  = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A killed or reset instruction must neither stall the pipe nor report a result.
    if (flush_i || rst_i) begin
      state_d = IDLE;
      busy_o  = 1'b0;
      done_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= MD_MUL;
      rem_q    <= '0;
      quo_q    <= '0;
      dmag_q   <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dmag_q   <= dmag_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/core_ex_stage_m.sv
// rtl/core_ex_stage_m.sv - RV32IM execute stage: forwarding, ALU, branch resolution, muldiv stall
module core_ex_stage_m
  import core_pkg::*;
#(
  parameter int XLEN               = 32,
  parameter int DIV_BITS_PER_CYCLE = 1,
  parameter bit FWD_MEM_EN         = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  input  logic [XLEN-1:0] rs1_dout_i,
  input  logic [XLEN-1:0] rs2_dout_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [4:0]      mem_rd_i,
  input  logic            mem_reg_write_i,
  input  logic [XLEN-1:0] mem_fwd_data_i,
  input  logic [4:0]      wb_rd_i,
  input  logic            wb_reg_write_i,
  input  logic [XLEN-1:0] rd_din_i,
  output logic            stall_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] alu_result_o,
  output logic            branch_taken_o,
  output logic [XLEN-1:0] pc_branch_o,
  output logic [XLEN-1:0] forward_in1_o,
  output logic [XLEN-1:0] forward_in2_o
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] fwd1, fwd2, op_a, op_b, alu_res, md_result;
  logic [SHW-1:0]  shamt;
  logic            is_m, uses_rs2, cond, md_busy, md_done;

  function automatic logic fwd_hit(input logic [4:0] rs, input logic [4:0] rd, input logic we);
    return we && (rs != 5'd0) && (rd == rs);
  endfunction

  // MEM is younger than WB, so its value wins when both target the same register.
  always_comb begin
    fwd1 = rs1_dout_i;
    if (FWD_MEM_EN && fwd_hit(rs1_i, mem_rd_i, mem_reg_write_i)) fwd1 = mem_fwd_data_i;
    else if (fwd_hit(rs1_i, wb_rd_i, wb_reg_write_i))          fwd1 = rd_din_i;
    fwd2 = rs2_dout_i;
    if (FWD_MEM_EN && fwd_hit(rs2_i, mem_rd_i, mem_reg_write_i)) fwd2 = mem_fwd_data_i;
    else if (fwd_hit(rs2_i, wb_rd_i, wb_reg_write_i))          fwd2 = rd_din_i;
  end

  assign is_m     = (opcode_i == OPCODE_R) && (funct7_i == FUNCT7_MULDIV);
  assign uses_rs2 = opcode_i inside {OPCODE_R, OPCODE_STORE, OPCODE_BRANCH, OPCODE_PIM};
  assign op_a     = (opcode_i == OPCODE_AUIPC) ? pc_i : fwd1;
  assign op_b     = uses_rs2 ? fwd2 : imm_i;
  assign shamt    = op_b[SHW-1:0];

  always_comb begin
    cond = 1'b0;
    case (funct3_i)
      3'b000:  cond = (fwd1 == fwd2);
      3'b001:  cond = (fwd1 != fwd2);
      3'b100:  cond = ($signed(fwd1) <  $signed(fwd2));
      3'b101:  cond = ($signed(fwd1) >= $signed(fwd2));
      3'b110:  cond = (fwd1 <  fwd2);
      3'b111:  cond = (fwd1 >= fwd2);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (funct3_i)
      3'b000:  alu_res = (opcode_i == OPCODE_R && funct7_i[5]) ? op_a - op_b : op_a + op_b;
      3'b001:  alu_res = op_a << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      3'b100:  alu_res = op_a ^ op_b;
      3'b101:  alu_res = funct7_i[5] ? $unsigned($signed(op_a) >>> shamt) : (op_a >> shamt);
      3'b110:  alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
    case (opcode_i)
      OPCODE_LUI:                              alu_res = imm_i;
      OPCODE_AUIPC, OPCODE_LOAD, OPCODE_STORE: alu_res = op_a + imm_i;
      OPCODE_JAL, OPCODE_JALR:                 alu_res = pc_i + XLEN'(4);
      OPCODE_BRANCH:                           alu_res = {{(XLEN-1){1'b0}}, cond};
      default: ;
    endcase
  end

  assign branch_taken_o = valid_i && !is_m && !flush_i &&
                          ((opcode_i == OPCODE_BRANCH && cond) ||
                           opcode_i == OPCODE_JAL || opcode_i == OPCODE_JALR);
  assign pc_branch_o    = (opcode_i == OPCODE_JALR) ? ((fwd1 + imm_i) & ~XLEN'(1)) : (pc_i + imm_i);

  core_muldiv_unit #(
    .XLEN              (XLEN),
    .DIV_BITS_PER_CYCLE(DIV_BITS_PER_CYCLE)
  ) u_muldiv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (valid_i && is_m),
    .op_i    (md_op_e'(funct3_i)),
    .a_i     (fwd1),
    .b_i     (fwd2),
    .flush_i (flush_i),
    .busy_o  (md_busy),
    .done_o  (md_done),
    .result_o(md_result)
  );

  assign stall_o        = md_busy;
  assign result_valid_o = !flush_i && !rst_i && (is_m ? md_done : valid_i);
  assign alu_result_o   = is_m ? md_result : alu_res;
  assign forward_in1_o  = fwd1;
  assign forward_in2_o  = fwd2;

endmodule

// File: tb/tb_core_ex_stage_m.sv
// tb/tb_core_ex_stage_m.sv - directed scoreboard bench for core_ex_stage_m (radix-2 and radix-16 divider)
module tb_core_ex_stage_m;
  import core_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid1, valid4, flush;
  logic [31:0] pc, rs1_dout, rs2_dout, imm, mem_fwd, rd_din;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, mem_rd, wb_rd;
  logic        mem_we, wb_we;

  logic        st1, rv1, bt1, st4, rv4, bt4;
  logic [31:0] res1, pcb1, fa1, fb1, res4, pcb4, fa4, fb4;

  typedef struct {
    string       tag;
    logic [31:0] val;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int ncmp  = 0;
  int nfail = 0;

  core_ex_stage_m #(.XLEN(32), .DIV_BITS_PER_CYCLE(1), .FWD_MEM_EN(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid1), .flush_i(flush), .pc_i(pc),
    .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7), .rs1_i(rs1), .rs2_i(rs2),
    .rs1_dout_i(rs1_dout), .rs2_dout_i(rs2_dout), .imm_i(imm),
    .mem_rd_i(mem_rd), .mem_reg_write_i(mem_we), .mem_fwd_data_i(mem_fwd),
    .wb_rd_i(wb_rd), .wb_reg_write_i(wb_we), .rd_din_i(rd_din),
    .stall_o(st1), .result_valid_o(rv1), .alu_result_o(res1), .branch_taken_o(bt1),
    .pc_branch_o(pcb1), .forward_in1_o(fa1), .forward_in2_o(fb1)
  );

  core_ex_stage_m #(.XLEN(32), .DIV_BITS_PER_CYCLE(4), .FWD_MEM_EN(1'b1)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid4), .flush_i(flush), .pc_i(pc),
    .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7), .rs1_i(rs1), .rs2_i(rs2),
    .rs1_dout_i(rs1_dout), .rs2_dout_i(rs2_dout), .imm_i(imm),
    .mem_rd_i(mem_rd), .mem_reg_write_i(mem_we), .mem_fwd_data_i(mem_fwd),
    .wb_rd_i(wb_rd), .wb_reg_write_i(wb_we), .rd_din_i(rd_din),
    .stall_o(st4), .result_valid_o(rv4), .alu_result_o(res4), .branch_taken_o(bt4),
    .pc_branch_o(pcb4), .forward_in1_o(fa4), .forward_in2_o(fb4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drv(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im);
    cycles(1);
    opcode = op;  funct3 = f3;  funct7 = f7;
    rs1 = r1;  rs2 = r2;  rs1_dout = d1;  rs2_dout = d2;  imm = im;
    mem_we = 1'b0;  wb_we = 1'b0;  mem_rd = 5'd0;  wb_rd = 5'd0;
  endtask

  // Single-cycle op on the radix-2 instance: result must appear in the same cycle without stall.
  task automatic alu_check(input string tag, input logic [31:0] expv);
    exp_t e;
    valid1 = 1'b1;
    sb.push_back('{tag, expv, 0});
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, rv1}, 32'd1);
    chk({tag, "_stall"}, {31'd0, st1}, 32'd0);
    e = sb.pop_front();
    chk(e.tag, res1, e.val);
  endtask

  task automatic m_case(input bit use4, input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input int lat);
    exp_t e;
    int   n, nst;
    drv(OPCODE_R, f3, FUNCT7_MULDIV, 5'd1, 5'd2, a, b, 32'd0);
    valid1 = !use4;
    valid4 = use4;
    sb.push_back('{tag, expv, lat});
    n   = 0;
    nst = 0;
    @(negedge clk);
    while (!(use4 ? rv4 : rv1) && n < 100) begin
      if (use4 ? st4 : st1) nst++;
      n++;
      @(negedge clk);
    end
    e = sb.pop_front();
    chk({e.tag, "_latency"}, n, e.lat);
    chk({e.tag, "_stall_cycles"}, nst, e.lat);
    chk({e.tag, "_done_stall"}, {31'd0, use4 ? st4 : st1}, 32'd0);
    chk(e.tag, use4 ? res4 : res1, e.val);
    cycles(1);
    valid1 = 1'b0;
    valid4 = 1'b0;
  endtask

  // Abort a radix-2 divide at cycle N+k with flush or reset, then watch for any stray result.
  task automatic abort_case(input string tag, input bit use_rst, input int k);
    int nrv, nst;
    drv(OPCODE_R, 3'b100, FUNCT7_MULDIV, 5'd1, 5'd2, 32'hFFFF_FFF9, 32'd2, 32'd0);
    valid1 = 1'b1;
    cycles(k - 1);
    @(negedge clk);
    chk({tag, "_busy_before"}, {31'd0, st1}, 32'd1);
    cycles(1);
    if (use_rst) rst = 1'b1;
    else         flush = 1'b1;
    @(negedge clk);
    chk({tag, "_stall_abort_cycle"}, {31'd0, st1}, 32'd0);
    chk({tag, "_valid_abort_cycle"}, {31'd0, rv1}, 32'd0);
    cycles(1);
    rst = 1'b0;
    flush = 1'b0;
    valid1 = 1'b0;
    nrv = 0;
    nst = 0;
    repeat (40) begin
      @(negedge clk);
      if (rv1) nrv++;
      if (st1) nst++;
    end
    chk({tag, "_no_result"}, nrv, 0);
    chk({tag, "_no_stall_after"}, nst, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;  valid1 = 1'b0;  valid4 = 1'b0;  flush = 1'b0;
    pc = 32'd0;  opcode = 7'd0;  funct3 = 3'd0;  funct7 = 7'd0;
    rs1 = 5'd0;  rs2 = 5'd0;  rs1_dout = 32'd0;  rs2_dout = 32'd0;  imm = 32'd0;
    mem_rd = 5'd0;  mem_we = 1'b0;  mem_fwd = 32'd0;  wb_rd = 5'd0;  wb_we = 1'b0;  rd_din = 32'd0;
    cycles(3);
    @(negedge clk);
    chk("reset_stall1", {31'd0, st1}, 32'd0);
    chk("reset_valid1", {31'd0, rv1}, 32'd0);
    chk("reset_stall4", {31'd0, st4}, 32'd0);
    chk("reset_valid4", {31'd0, rv4}, 32'd0);
    cycles(1);
    rst = 1'b0;

    drv(OPCODE_R, 3'b000, 7'd0, 5'd1, 5'd2, 32'd100, 32'd7, 32'd0);
    mem_rd = 5'd1;  mem_we = 1'b1;  mem_fwd = 32'd5;  wb_rd = 5'd1;  wb_we = 1'b1;  rd_din = 32'd9;
    alu_check("add_mem_over_wb", 32'd12);
    chk("fwd_in1_mem", fa1, 32'd5);
    chk("fwd_in2_base", fb1, 32'd7);

    drv(OPCODE_R, 3'b000, 7'd0, 5'd1, 5'd2, 32'd100, 32'd7, 32'd0);
    wb_rd = 5'd1;  wb_we = 1'b1;  rd_din = 32'd9;  mem_rd = 5'd1;  mem_fwd = 32'd5;
    alu_check("add_wb_only", 32'd16);

    drv(OPCODE_R, 3'b000, 7'd0, 5'd0, 5'd2, 32'd100, 32'd7, 32'd0);
    mem_rd = 5'd0;  mem_we = 1'b1;  mem_fwd = 32'd5;  wb_rd = 5'd0;  wb_we = 1'b1;  rd_din = 32'd9;
    alu_check("add_x0_no_fwd", 32'd107);

    drv(OPCODE_R, 3'b000, 7'b0100000, 5'd3, 5'd4, 32'd100, 32'd7, 32'd0);
    alu_check("sub", 32'd93);

    drv(OPCODE_I, 3'b101, 7'b0100000, 5'd3, 5'd0, 32'h8000_0000, 32'd0, 32'h0000_0404);
    alu_check("srai_masked", 32'hF800_0000);

    drv(OPCODE_AUIPC, 3'b000, 7'd0, 5'd1, 5'd0, 32'd0, 32'd0, 32'h0000_5000);
    pc = 32'h0000_1000;  mem_rd = 5'd1;  mem_we = 1'b1;  mem_fwd = 32'd5;
    alu_check("auipc", 32'h0000_6000);

    drv(OPCODE_BRANCH, 3'b000, 7'd0, 5'd3, 5'd4, 32'h55, 32'h55, 32'h20);
    pc = 32'h0000_0100;
    valid1 = 1'b1;
    @(negedge clk);
    chk("beq_taken", {31'd0, bt1}, 32'd1);
    chk("beq_target", pcb1, 32'h0000_0120);

    drv(OPCODE_BRANCH, 3'b100, 7'd0, 5'd3, 5'd4, 32'd5, 32'hFFFF_FFFF, 32'h20);
    @(negedge clk);
    chk("blt_not_taken", {31'd0, bt1}, 32'd0);
    cycles(1);
    valid1 = 1'b0;

    m_case(1'b0, "mul",    3'b000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1);
    m_case(1'b0, "mulhu",  3'b011, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1);
    m_case(1'b0, "mulh",   3'b001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1);
    m_case(1'b0, "mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1);
    m_case(1'b0, "div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
    m_case(1'b0, "rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
    m_case(1'b0, "div_7_m2",  3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
    m_case(1'b0, "rem_7_m2",  3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 32);
    m_case(1'b0, "divu_by0",  3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
    m_case(1'b0, "remu_by0",  3'b111, 32'd100, 32'd0, 32'd100, 1);
    m_case(1'b0, "div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    m_case(1'b0, "rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    abort_case("flush_n5", 1'b0, 5);
    abort_case("rst_n3",   1'b1, 3);
    m_case(1'b0, "div_after_abort", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);

    m_case(1'b1, "divu_r16", 3'b101, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 8);
    m_case(1'b1, "remu_r16", 3'b111, 32'hFFFF_FFFF, 32'd7, 32'd3, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
